// File: rtl/coinc_pkg.sv
// Shared definitions for the coincidence-counting datapath: selector codes and count width.
package coinc_pkg;

    localparam int unsigned COUNT_W = 8;
    localparam int unsigned SEL_W   = 4;

    localparam logic [SEL_W-1:0] SEL_A    = 4'd0;
    localparam logic [SEL_W-1:0] SEL_B    = 4'd1;
    localparam logic [SEL_W-1:0] SEL_BP   = 4'd2;
    localparam logic [SEL_W-1:0] SEL_AP   = 4'd3;
    localparam logic [SEL_W-1:0] SEL_AB   = 4'd4;
    localparam logic [SEL_W-1:0] SEL_ABP  = 4'd5;
    localparam logic [SEL_W-1:0] SEL_APB  = 4'd6;
    localparam logic [SEL_W-1:0] SEL_APBP = 4'd7;
    localparam logic [SEL_W-1:0] SEL_ABBP = 4'd8;
    localparam logic [SEL_W-1:0] SEL_MAX  = SEL_ABBP;

endpackage

// File: rtl/output_select_mux.sv
// Registered 9:1 select of singles/coincidence counts onto the readout bus,
// with a flag for selector codes beyond the last defined channel.
module output_select_mux
    import coinc_pkg::*;
#(
    parameter int unsigned W = COUNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] s,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     bp,
    input  logic [W-1:0]     ap,
    input  logic [W-1:0]     ab,
    input  logic [W-1:0]     abp,
    input  logic [W-1:0]     apb,
    input  logic [W-1:0]     apbp,
    input  logic [W-1:0]     abbp,
    output logic [W-1:0]     send,
    output logic             sel_err
);

    logic [W-1:0] send_d,    send_q;
    logic         sel_err_d, sel_err_q;

    // Selector decode; unused codes drive zero and raise the error flag.
    always_comb begin
        send_d    = '0;
        sel_err_d = 1'b0;
        case (s)
            SEL_A:    send_d = a;
            SEL_B:    send_d = b;
            SEL_BP:   send_d = bp;
            SEL_AP:   send_d = ap;
            SEL_AB:   send_d = ab;
            SEL_ABP:  send_d = abp;
            SEL_APB:  send_d = apb;
            SEL_APBP: send_d = apbp;
            SEL_ABBP: send_d = abbp;
            default:  sel_err_d = (s > SEL_MAX);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            send_q    <= send_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign send    = send_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_output_select_mux.sv
// Scoreboard bench for output_select_mux: driver pushes expected results, monitor pops and compares.
module tb_output_select_mux;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] send;
        logic         err;
        logic [3:0]   sel;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [3:0]   s;
    logic [W-1:0] cnt [9];
    logic [W-1:0] nxt [9];
    logic [W-1:0] send;
    logic         sel_err;

    exp_t sbq [$];
    int   errors = 0;
    int   checks = 0;

    output_select_mux #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s       (s),
        .a       (cnt[0]),
        .b       (cnt[1]),
        .bp      (cnt[2]),
        .ap      (cnt[3]),
        .ab      (cnt[4]),
        .abp     (cnt[5]),
        .apb     (cnt[6]),
        .apbp    (cnt[7]),
        .abbp    (cnt[8]),
        .send    (send),
        .sel_err (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the selector indexes the count table, anything past the table is an error.
    function automatic exp_t model(input logic [3:0] sel);
        exp_t e;
        int   idx;
        idx    = int'(sel);
        e.sel  = sel;
        if (idx < 9) begin
            e.send = cnt[idx];
            e.err  = 1'b0;
        end else begin
            e.send = '0;
            e.err  = 1'b1;
        end
        return e;
    endfunction

    // Apply the selector and staged data at a falling edge; the next rising edge captures them.
    task automatic drive(input logic [3:0] sel);
        @(negedge clk);
        for (int i = 0; i < 9; i++) cnt[i] = nxt[i];
        s = sel;
        sbq.push_back(model(sel));
    endtask

    task automatic set_base();
        for (int i = 0; i < 9; i++) nxt[i] = W'((i + 1) * 10);
    endtask

    // Monitor: each rising edge consumes at most one pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check($sformatf("send(s=%0d)", e.sel), send, e.send);
                check($sformatf("sel_err(s=%0d)", e.sel), W'(sel_err), W'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_base();
        for (int i = 0; i < 9; i++) cnt[i] = nxt[i];
        s = 4'd3;

        // Reset is asynchronous: outputs must be clear before any clock edge.
        #1;
        check("reset_send_noclk", send, '0);
        check("reset_err_noclk", W'(sel_err), '0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_send_held", send, '0);
        check("reset_err_held", W'(sel_err), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep every valid selector, ten cycles each.
        for (int v = 0; v < 9; v++)
            repeat (10) drive(4'(v));

        // Wrap sequence.
        for (int i = 0; i < 15; i++) drive(4'(i % 9));

        // Out-of-range codes then recovery.
        drive(4'd9);
        drive(4'd15);
        drive(4'd4);
        drive(4'd12);
        drive(4'd4);

        // Data change with selector fixed on abbp; other inputs moving must not matter.
        drive(4'd8);
        nxt[8] = 8'd255; drive(4'd8);
        nxt[0] = 8'd1; nxt[4] = 8'd2; drive(4'd8);
        nxt[8] = 8'd0; drive(4'd8);
        nxt[7] = 8'd77; drive(4'd8);

        // Mid-run reset pulsed between edges.
        set_base();
        drive(4'd6);
        drive(4'd6);
        @(posedge clk);
        #2;
        check("pre_reset_send", send, 8'd70);
        rst_n = 1'b0;
        #1;
        check("midreset_send", send, '0);
        check("midreset_err", W'(sel_err), '0);
        #1;
        rst_n = 1'b1;
        drive(4'd6);
        drive(4'd9);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_err_clear", W'(sel_err), '0);
        #1;
        rst_n = 1'b1;
        drive(4'd2);

        // Randomized selector and data.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 9; k++)
                if ($urandom_range(0, 2) == 0) nxt[k] = W'($urandom);
            drive(4'($urandom_range(0, 15)));
        end

        // Drain: bounded wait for outstanding expectations.
        for (int t = 0; t < 10 && sbq.size() > 0; t++) @(posedge clk);
        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
